gpc607_seq_accum: RTL and testbench
===================================

Name: gpc607_seq_accum

Overview:
- Multi-cycle weighted-popcount engine that time-shares one gpc607_5 counter instance across NCHUNK operand chunks.
- Each chunk holds 7 bits of weight 1 and 6 bits of weight 4. The block sequences the chunks through the counter and accumulates the 5-bit results into one weighted sum.
- Sits between a wide bit-vector producer and a consumer, behind valid/ready handshakes on both sides.
- Trades area against latency compared with a fully unrolled compressor tree.

Parameters:
- NCHUNK, 4, number of 7+6-bit chunks per operand; must be >= 1.
- SUM_W, 7, width of sum output; must be >= clog2(31*NCHUNK+1). Default covers a maximum of 124.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_w1  input  7*NCHUNK  weight-1 bits; chunk k = in_w1[7k+6:7k].
- in_w4  input  6*NCHUNK  weight-4 bits; chunk k = in_w4[6k+5:6k].
- out_valid  output  1  sum valid.
- out_ready  input  1  consumer accepts sum.
- sum  output  SUM_W  sum over all chunks of (popcount(w1 chunk) + 4*popcount(w4 chunk)).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; chunk counter, accumulator and operand registers = 0.
  - Outputs: in_ready=1 (it follows state), out_valid=0, sum=0, busy=0.
  - Reset takes effect immediately at any point, including mid-RUN or in DONE. Any in-flight operand is dropped. On release the block is in IDLE with no spurious out_valid.
- Datapath:
  - One gpc607_5 instance, ports (src0[6:0], src2[5:0], dst[4:0]).
  - src0/src2 are driven from the latched chunk selected by the counter.
  - dst is zero-extended to SUM_W and added to the accumulator. No overflow is possible given the SUM_W rule.
- State IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch in_w1/in_w4, clear the accumulator, set cnt=0, go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle: acc <= acc + dst(chunk[cnt]); cnt <= cnt+1.
  - When the chunk at cnt=NCHUNK-1 is added, go to DONE.
  - Input changes during RUN are ignored, since the operand is latched.
- State DONE:
  - out_valid=1; sum=acc, held stable while out_ready=0.
  - On out_ready: out_valid drops the next cycle and state goes to IDLE.
- Latency:
  - out_valid rises NCHUNK cycles after the accepting edge.
  - The next operand can be accepted one cycle after the out_ready handshake, since in_ready is only high in IDLE. Throughput is one result per NCHUNK+2 cycles minimum.
- NCHUNK=1: RUN lasts one cycle, then DONE.
- out_ready asserted while out_valid=0 has no effect.
- in_valid while not in_ready: held off by the producer, not lost. The operand must stay stable per the valid/ready rule.

Optional Feature:
- Macro: GPC607_SEQ_PIPE_EN.
- Defined:
  - A register is inserted between gpc607_5 dst and the accumulator adder, breaking the counter-to-adder path.
  - RUN lasts NCHUNK+1 cycles: the first cycle only fills the register, and the last cycle drains the final chunk.
  - out_valid rises NCHUNK+1 cycles after accept.
  - The pipe register clears on reset and on accept.
- Undefined: combinational dst into the adder; latency exactly as in Behaviour.
- Sum values are identical in both builds.

Test Plan:
- Zero operand (NCHUNK=4): in_w1=0, in_w4=0, out_ready=1 -> out_valid after 4 cycles (5 with PIPE_EN), sum=0, then in_ready=1 the cycle after the handshake.
- All ones (NCHUNK=4): in_w1=all 1s, in_w4=all 1s -> sum=124 (0x7C).
- Single-chunk position: chunk0 w1=0x30, w4=0x2b, chunks 1-3 zero -> sum=18. Same values placed in chunk3 only -> sum=18. Chunk0 w1=0x6f, w4=0x0e and chunk2 w1=0x26, w4=0x01, others zero -> 6+12+3+4 = sum=25.
- Back-pressure: hold out_ready=0 for 6 cycles in DONE -> out_valid=1 and sum constant; in_ready=0 throughout, and an in_valid pulse is not accepted; releasing out_ready -> IDLE next cycle.
- Reset mid-operation: assert rst asynchronously (between clock edges) during the 2nd RUN cycle -> out_valid=0, sum=0, busy=0 immediately. After release, a new operand w1=0x7f (chunk0) gives sum=7, with no residue from the aborted operand.
- Back-to-back with random operands: 50 randomized operands with random in_valid/out_ready gaps -> every sum matches a bench-computed weighted popcount, with no drops and no duplicates. Run with and without GPC607_SEQ_PIPE_EN.

Source files
------------

// File: rtl/gpc607_seq_accum.sv
// Sequential weighted popcount: one gpc607_5 counter time-shared across NCHUNK 7+6-bit chunks.
// Optional macro GPC607_SEQ_PIPE_EN registers the counter output ahead of the accumulator adder.

module gpc607_5 (
    input  logic [6:0] src0,
    input  logic [5:0] src2,
    output logic [4:0] dst
);
    logic [2:0] w_c0;
    logic [2:0] w_c2;

    always_comb begin
        w_c0 = '0;
        w_c2 = '0;
        for (int i = 0; i < 7; i++) w_c0 = w_c0 + 3'(src0[i]);
        for (int i = 0; i < 6; i++) w_c2 = w_c2 + 3'(src2[i]);
        // Max 7 + 4*6 = 31, so the 5-bit result never overflows.
        dst = {2'b00, w_c0} + {w_c2, 2'b00};
    end
endmodule

module gpc607_seq_accum #(
    parameter int NCHUNK = 4,
    parameter int SUM_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7*NCHUNK-1:0]   in_w1,
    input  logic [6*NCHUNK-1:0]   in_w4,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SUM_W-1:0]      sum,
    output logic                  busy
);
`ifdef GPC607_SEQ_PIPE_EN
    localparam int RUN_LEN = NCHUNK + 1;
`else
    localparam int RUN_LEN = NCHUNK;
`endif
    localparam int CNT_W = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                r_state, w_next;
    logic [7*NCHUNK-1:0]   r_w1;
    logic [6*NCHUNK-1:0]   r_w4;
    logic [CNT_W-1:0]      r_cnt;
    logic [SUM_W-1:0]      r_acc;
    logic [6:0]            w_src0;
    logic [5:0]            w_src2;
    logic [4:0]            w_dst;
    logic [SUM_W-1:0]      w_addend;
    logic                  w_accept;

    assign w_accept = (r_state == S_IDLE) && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_next = S_RUN;
            end
            S_RUN:  if (r_cnt == CNT_LAST) w_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Chunk select; a count past the last chunk (pipe drain cycle) feeds zeros.
    always_comb begin
        w_src0 = '0;
        w_src2 = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_src0 = r_w1[7*k +: 7];
                w_src2 = r_w4[6*k +: 6];
            end
        end
    end

    gpc607_5 u_gpc (
        .src0 (w_src0),
        .src2 (w_src2),
        .dst  (w_dst)
    );

`ifdef GPC607_SEQ_PIPE_EN
    logic [4:0] r_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_pipe <= '0;
        else if (w_accept)           r_pipe <= '0;
        else if (r_state == S_RUN)   r_pipe <= w_dst;
    end

    assign w_addend = SUM_W'(r_pipe);
`else
    assign w_addend = SUM_W'(w_dst);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w1  <= '0;
            r_w4  <= '0;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_w1  <= in_w1;
            r_w4  <= in_w4;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (r_state == S_RUN) begin
            r_acc <= r_acc + w_addend;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign sum = r_acc;
endmodule

// File: tb/tb_gpc607_seq_accum.sv
// Self-checking bench for gpc607_seq_accum (NCHUNK=4): vector table, corner sequences, random scoreboard.

module tb_gpc607_seq_accum;
    localparam int N  = 4;
    localparam int SW = 7;
`ifdef GPC607_SEQ_PIPE_EN
    localparam int LAT = N + 1;
`else
    localparam int LAT = N;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7*N-1:0] in_w1;
    logic [6*N-1:0] in_w4;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] sum;
    logic          busy;

    gpc607_seq_accum #(.NCHUNK(N), .SUM_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_w1     (in_w1),
        .in_w4     (in_w4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Chunking does not change the total: every w1 bit is worth 1, every w4 bit is worth 4.
    function automatic int ref_sum(input logic [7*N-1:0] w1, input logic [6*N-1:0] w4);
        int s = 0;
        for (int i = 0; i < 7*N; i++) s += int'(w1[i]);
        for (int i = 0; i < 6*N; i++) s += 4 * int'(w4[i]);
        return s;
    endfunction

    // Called at posedge+1 with the DUT in IDLE; returns sum and cycles from accept to out_valid.
    task automatic run_op(input logic [7*N-1:0] w1, input logic [6*N-1:0] w4,
                          output int got, output int lat);
        in_w1 = w1;
        in_w4 = w4;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = int'(sum);
    endtask

    typedef struct {
        logic [7*N-1:0] w1;
        logic [6*N-1:0] w4;
        int             exp;
    } vec_t;

    vec_t vecs[6];
    int   got, lat;
    int   held;
    int   exp_q[$];
    int   sent, recv;
    logic acc_now;

    initial begin
        vecs[0] = '{28'h0,        24'h0,       0};
        vecs[1] = '{28'hFFFFFFF,  24'hFFFFFF,  124};
        vecs[2] = '{28'h30,       24'h2b,      18};
        vecs[3] = '{28'h30 << 21, 24'h2b << 18, 18};
        vecs[4] = '{(28'h26 << 14) | 28'h6f, (24'h01 << 12) | 24'h0e, 25};
        vecs[5] = '{28'h1020408,  24'h041041,  4 + 16};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_w1 = '0; in_w4 = '0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector table, consumer always ready.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            run_op(vecs[i].w1, vecs[i].w4, got, lat);
            chk("tbl_sum", got, vecs[i].exp);
            chk("tbl_lat", lat, LAT);
            @(posedge clk); #1;
            chk("tbl_idle_ready", in_ready, 1);
            chk("tbl_valid_drop", out_valid, 0);
        end

        // Back-pressure in DONE with a stray in_valid pulse.
        out_ready = 1'b0;
        run_op(28'h1234567, 24'hABCDEF, got, lat);
        chk("bp_sum", got, ref_sum(28'h1234567, 24'hABCDEF));
        held = got;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin in_w1 = 28'hFFFFFFF; in_w4 = 24'hFFFFFF; in_valid = 1'b1; end
            if (c == 3) in_valid = 1'b0;
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_sum_hold", sum, held);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("bp_pulse_dropped", busy, 0);

        // Asynchronous reset during the second RUN cycle.
        in_w1 = 28'hFFFFFFF; in_w4 = 24'hFFFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_valid", out_valid, 0);
        run_op(28'h7f, 24'h0, got, lat);
        chk("post_rst_sum", got, 7);
        chk("post_rst_lat", lat, LAT);
        @(posedge clk); #1;

        // Randomized traffic against a scoreboard.
        sent = 0; recv = 0; acc_now = 1'b0;
        for (int cyc = 0; cyc < 5000 && recv < 50; cyc++) begin
            @(posedge clk); #1;
            if (acc_now) in_valid = 1'b0;
            acc_now = 1'b0;
            if (!in_valid && sent < 50 && $urandom_range(0, 2) != 0) begin
                in_w1 = 28'($urandom);
                in_w4 = 24'($urandom);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sum(in_w1, in_w4));
                sent++;
                acc_now = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_spurious", 1, 0);
                end else begin
                    chk("rand_sum", sum, exp_q.pop_front());
                end
                recv++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rand_sent", sent, 50);
        chk("rand_recv", recv, 50);
        chk("rand_q_empty", exp_q.size(), 0);
        chk("rand_no_extra", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
